// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb : register file with two write ports, two read ports and a
// per-register busy (pending producer) scoreboard.
//
// Parameters
//   DBITS    : width of each register
//   REG_BITS : register index width, 2**REG_BITS registers
//   ZERO_R0  : 1 = r0 reads as zero, ignores writes and reserves
//   BYPASS   : 1 = a write enabled this cycle is forwarded to matching reads
//
// Ports
//   CLK, RESET          : rising-edge clock, asynchronous active-high reset
//   WrEn0, RD0, In0     : write port 0 (enable, destination index, data)
//   WrEn1, RD1, In1     : write port 1; wins over port 0 on the same index
//   RS1, RS2            : read indices
//   Out1, Out2          : combinational read data for RS1 / RS2
//   RsvEn, RsvReg       : reserve request, sets the busy bit of RsvReg
//   Busy1, Busy2        : busy bit of RS1 / RS2 as currently stored
//
// Interface timing: writes and reserves are single-cycle enables sampled on
// the rising edge; there is no back-pressure, so every enabled request
// seen at an edge outside reset takes effect at that edge.
// ---------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DBITS    = 32,
  parameter int REG_BITS = 4,
  parameter int ZERO_R0  = 0,
  parameter int BYPASS   = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                WrEn0,
  input  logic [REG_BITS-1:0] RD0,
  input  logic [DBITS-1:0]    In0,
  input  logic                WrEn1,
  input  logic [REG_BITS-1:0] RD1,
  input  logic [DBITS-1:0]    In1,
  input  logic [REG_BITS-1:0] RS1,
  input  logic [REG_BITS-1:0] RS2,
  output logic [DBITS-1:0]    Out1,
  output logic [DBITS-1:0]    Out2,
  input  logic                RsvEn,
  input  logic [REG_BITS-1:0] RsvReg,
  output logic                Busy1,
  output logic                Busy2
);

  localparam int NREGS = 1 << REG_BITS;

  logic [DBITS-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  // Requests aimed at a hardwired r0 are dropped before they reach state.
  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;

  assign wr0_ok = WrEn0 && !((ZERO_R0 != 0) && (RD0 == '0));
  assign wr1_ok = WrEn1 && !((ZERO_R0 != 0) && (RD1 == '0));
  assign rsv_ok = RsvEn && !((ZERO_R0 != 0) && (RsvReg == '0));

  // Later non-blocking assignments win: port 1 over port 0 on data, and a
  // reserve over a write clear on the busy bit (the reserve names a newer
  // producer than the write that is retiring).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0_ok) begin
        regs[RD0] <= In0;
        busy[RD0] <= 1'b0;
      end
      if (wr1_ok) begin
        regs[RD1] <= In1;
        busy[RD1] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[RsvReg] <= 1'b1;
      end
    end
  end

  // Two identical read ports, built from one loop.
  logic [REG_BITS-1:0] rs    [2];
  logic [DBITS-1:0]    rdata [2];
  logic [1:0]          rbusy;

  assign rs[0] = RS1;
  assign rs[1] = RS2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[rs[p]];
      rbusy[p] = busy[rs[p]];
      // Forwarding only affects data; busy always reflects stored state.
      if (BYPASS != 0) begin
        if (wr1_ok && (RD1 == rs[p])) begin
          rdata[p] = In1;
        end else if (wr0_ok && (RD0 == rs[p])) begin
          rdata[p] = In0;
        end
      end
      if ((ZERO_R0 != 0) && (rs[p] == '0)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign Out1  = rdata[0];
  assign Out2  = rdata[1];
  assign Busy1 = rbusy[0];
  assign Busy2 = rbusy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb : bench for reg_file_sb. Three instances share one set of
// inputs: inst 0 = defaults (bypass on, r0 writable), inst 1 = ZERO_R0=1,
// inst 2 = BYPASS=0. A reference model holds register contents and busy
// bits for the "r0 writable" and "r0 hardwired" cases.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int RB = 4;
  localparam int NR = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wr_en0, wr_en1, rsv_en;
  logic [RB-1:0] rd0, rd1, rs1, rs2, rsv_reg;
  logic [DW-1:0] in0, in1;
  logic [DW-1:0] out1 [3];
  logic [DW-1:0] out2 [3];
  logic [2:0]    bsy1, bsy2;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_sb #(.DBITS(DW), .REG_BITS(RB), .ZERO_R0(0), .BYPASS(1)) dut_a (
    .CLK(clk), .RESET(rst), .WrEn0(wr_en0), .RD0(rd0), .In0(in0),
    .WrEn1(wr_en1), .RD1(rd1), .In1(in1), .RS1(rs1), .RS2(rs2),
    .Out1(out1[0]), .Out2(out2[0]), .RsvEn(rsv_en), .RsvReg(rsv_reg),
    .Busy1(bsy1[0]), .Busy2(bsy2[0]));

  reg_file_sb #(.DBITS(DW), .REG_BITS(RB), .ZERO_R0(1), .BYPASS(1)) dut_z (
    .CLK(clk), .RESET(rst), .WrEn0(wr_en0), .RD0(rd0), .In0(in0),
    .WrEn1(wr_en1), .RD1(rd1), .In1(in1), .RS1(rs1), .RS2(rs2),
    .Out1(out1[1]), .Out2(out2[1]), .RsvEn(rsv_en), .RsvReg(rsv_reg),
    .Busy1(bsy1[1]), .Busy2(bsy2[1]));

  reg_file_sb #(.DBITS(DW), .REG_BITS(RB), .ZERO_R0(0), .BYPASS(0)) dut_n (
    .CLK(clk), .RESET(rst), .WrEn0(wr_en0), .RD0(rd0), .In0(in0),
    .WrEn1(wr_en1), .RD1(rd1), .In1(in1), .RS1(rs1), .RS2(rs2),
    .Out1(out1[2]), .Out2(out2[2]), .RsvEn(rsv_en), .RsvReg(rsv_reg),
    .Busy1(bsy1[2]), .Busy2(bsy2[2]));

  // ---------------- reference model ----------------
  // index 0: r0 is an ordinary register, index 1: r0 hardwired to zero
  logic [DW-1:0] m_mem  [2][NR];
  logic          m_busy [2][NR];

  task automatic model_clear();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < NR; i++) begin
        m_mem[z][i]  = '0;
        m_busy[z][i] = 1'b0;
      end
  endtask

  // Effect of one rising edge: writes land (port 1 last so it wins), writes
  // retire their busy bit, then a reserve marks its register pending.
  task automatic model_edge();
    if (!rst) begin
      for (int z = 0; z < 2; z++) begin
        if (wr_en0 && !(z == 1 && rd0 == 0)) begin
          m_mem[z][rd0] = in0; m_busy[z][rd0] = 1'b0;
        end
        if (wr_en1 && !(z == 1 && rd1 == 0)) begin
          m_mem[z][rd1] = in1; m_busy[z][rd1] = 1'b0;
        end
        if (rsv_en && !(z == 1 && rsv_reg == 0)) m_busy[z][rsv_reg] = 1'b1;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_out(int z, int byp, logic [RB-1:0] rs);
    if (z == 1 && rs == 0) return '0;
    if (byp == 1 && wr_en1 && rd1 == rs) return in1;
    if (byp == 1 && wr_en0 && rd0 == rs) return in0;
    return m_mem[z][rs];
  endfunction

  function automatic logic exp_busy(int z, logic [RB-1:0] rs);
    if (z == 1 && rs == 0) return 1'b0;
    return m_busy[z][rs];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    wr_en0 = 0; wr_en1 = 0; rsv_en = 0;
    rd0 = 0; rd1 = 0; in0 = 0; in1 = 0; rsv_reg = 0; rs1 = 0; rs2 = 0;
  endtask

  // Inputs change on the falling edge; one rising edge is applied here.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < NR; a++)
      for (int c = 0; c < NR; c++) begin
        rs1 = a[RB-1:0]; rs2 = c[RB-1:0];
        #1;
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (out1[k] !== '0 || out2[k] !== '0 || bsy1[k] !== 1'b0 || bsy2[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sweep inst%0d rs=%0d/%0d got out=%h/%h busy=%b/%b need 0", k, a, c,
                     out1[k], out2[k], bsy1[k], bsy2[k]);
          end
        end
      end
    @(negedge clk);
  endtask

  task automatic test_no_write();
    drive_idle();
    wr_en0 = 0; rd0 = 0; in0 = 42;
    tick();
    drive_idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out1[k] !== '0) begin
        n_fail++;
        $display("FAIL no_write inst%0d got %h need 0", k, out1[k]);
      end
    end
  endtask

  task automatic test_fib();
    int fib [9] = '{1, 1, 2, 3, 5, 8, 13, 21, 34};
    logic [DW-1:0] e1, e2;
    for (int i = 0; i < 9; i++) begin
      drive_idle();
      if (i % 2 == 0) begin wr_en0 = 1; rd0 = i[RB-1:0]; in0 = fib[i]; end
      else            begin wr_en1 = 1; rd1 = i[RB-1:0]; in1 = fib[i]; end
      rs1 = i[RB-1:0];
      rs2 = $urandom_range(0, NR - 1);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (out1[k] !== exp_out(k == 1, k != 2, rs1)) begin
          n_fail++;
          $display("FAIL fib_bypass inst%0d r%0d got %h need %h", k, i, out1[k],
                   exp_out(k == 1, k != 2, rs1));
        end
      end
      tick();
    end
    drive_idle();
    for (int a = 0; a < NR; a++)
      for (int c = 0; c < NR; c++) begin
        rs1 = a[RB-1:0]; rs2 = c[RB-1:0];
        #1;
        for (int k = 0; k < 3; k++) begin
          e1 = (k == 1 && a == 0) ? 0 : (a < 9 ? fib[a] : 0);
          e2 = (k == 1 && c == 0) ? 0 : (c < 9 ? fib[c] : 0);
          n_tests++;
          if (out1[k] !== e1 || out2[k] !== e2 || bsy1[k] !== 1'b0 || bsy2[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL fib_sweep inst%0d rs=%0d/%0d got %h/%h busy %b/%b need %h/%h busy 0",
                     k, a, c, out1[k], out2[k], bsy1[k], bsy2[k], e1, e2);
          end
        end
      end
    @(negedge clk);
  endtask

  task automatic test_dual_conflict();
    logic [DW-1:0] pre [3] = '{9, 9, 3};
    drive_idle();
    wr_en0 = 1; wr_en1 = 1; rd0 = 3; rd1 = 3; in0 = 7; in1 = 9; rs1 = 3; rs2 = 3;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out1[k] !== pre[k] || out2[k] !== pre[k]) begin
        n_fail++;
        $display("FAIL dual_pre inst%0d got %h/%h need %h", k, out1[k], out2[k], pre[k]);
      end
    end
    tick();
    drive_idle();
    rs1 = 3; rs2 = 3;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out1[k] !== 32'd9 || out2[k] !== 32'd9) begin
        n_fail++;
        $display("FAIL dual_post inst%0d got %h/%h need 9", k, out1[k], out2[k]);
      end
    end
  endtask

  task automatic test_scoreboard();
    drive_idle();
    rsv_en = 1; rsv_reg = 5; rs1 = 5;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bsy1[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL rsv_same_cycle inst%0d got busy %b need 0", k, bsy1[k]);
      end
    end
    tick();
    drive_idle();
    rs1 = 5;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bsy1[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL rsv_set inst%0d got busy %b need 1", k, bsy1[k]);
      end
    end
    wr_en0 = 1; rd0 = 5; in0 = 8;
    tick();
    drive_idle();
    rs1 = 5;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bsy1[k] !== 1'b0 || out1[k] !== 32'd8) begin
        n_fail++;
        $display("FAIL write_clears inst%0d got busy %b out %h need busy 0 out 8", k, bsy1[k], out1[k]);
      end
    end
    rsv_en = 1; rsv_reg = 5; wr_en1 = 1; rd1 = 5; in1 = 4;
    tick();
    drive_idle();
    rs1 = 5;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bsy1[k] !== 1'b1 || out1[k] !== 32'd4) begin
        n_fail++;
        $display("FAIL rsv_beats_write inst%0d got busy %b out %h need busy 1 out 4", k, bsy1[k], out1[k]);
      end
    end
  endtask

  task automatic test_zero_r0();
    logic [DW-1:0] e_out [3] = '{55, 0, 55};
    logic          e_bsy [3] = '{1'b1, 1'b0, 1'b1};
    drive_idle();
    wr_en0 = 1; rd0 = 0; in0 = 55; rsv_en = 1; rsv_reg = 0; rs1 = 0;
    tick();
    drive_idle();
    rs1 = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out1[k] !== e_out[k] || bsy1[k] !== e_bsy[k]) begin
        n_fail++;
        $display("FAIL r0_write inst%0d got out %h busy %b need out %h busy %b", k, out1[k], bsy1[k],
                 e_out[k], e_bsy[k]);
      end
    end
    // assert reset between edges; contents must vanish without a clock
    #2;
    rs1 = 5;
    rst = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out1[k] !== '0 || bsy1[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset inst%0d got out %h busy %b need 0", k, out1[k], bsy1[k]);
      end
    end
    for (int a = 0; a < NR; a++) begin
      rs1 = a[RB-1:0]; rs2 = 4'(NR - 1 - a);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (out1[k] !== '0 || out2[k] !== '0 || bsy1[k] !== 1'b0 || bsy2[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_hold inst%0d rs=%0d got %h/%h busy %b/%b need 0", k, a,
                   out1[k], out2[k], bsy1[k], bsy2[k]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        rst = 1'b1;
        model_clear();
      end else begin
        rst = 1'b0;
      end
      wr_en0  = 1'($urandom_range(0, 1));
      wr_en1  = 1'($urandom_range(0, 1));
      rsv_en  = 1'($urandom_range(0, 1));
      rd0     = 4'($urandom_range(0, NR - 1));
      rd1     = ($urandom_range(0, 3) == 0) ? rd0 : 4'($urandom_range(0, NR - 1));
      rsv_reg = ($urandom_range(0, 3) == 0) ? rd1 : 4'($urandom_range(0, NR - 1));
      in0     = $urandom;
      in1     = $urandom;
      rs1     = ($urandom_range(0, 2) == 0) ? rd0 : 4'($urandom_range(0, NR - 1));
      rs2     = ($urandom_range(0, 2) == 0) ? rd1 : 4'($urandom_range(0, NR - 1));
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (out1[k] !== exp_out(k == 1, k != 2, rs1) || out2[k] !== exp_out(k == 1, k != 2, rs2) ||
            bsy1[k] !== exp_busy(k == 1, rs1) || bsy2[k] !== exp_busy(k == 1, rs2)) begin
          n_fail++;
          $display("FAIL random n=%0d inst%0d rs=%0d/%0d got %h/%h busy %b/%b need %h/%h busy %b/%b",
                   n, k, rs1, rs2, out1[k], out2[k], bsy1[k], bsy2[k],
                   exp_out(k == 1, k != 2, rs1), exp_out(k == 1, k != 2, rs2),
                   exp_busy(k == 1, rs1), exp_busy(k == 1, rs2));
        end
      end
      tick();
    end
    rst = 1'b0;
    drive_idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_no_write();
    test_fib();
    test_dual_conflict();
    test_scoreboard();
    test_zero_r0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
